// File: rtl/multi_delta_calc_pkg.sv
// Shared types and constants for the multi-channel shortest-path delta calculator.
// Holds the FSM state encoding, the rotation-direction encodings and an index-width helper.
package multi_delta_calc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CALC    = 2'd1,
      ST_RESOLVE = 2'd2,
      ST_REPORT  = 2'd3
   } state_e;

   localparam logic DIR_CW  = 1'b0;
   localparam logic DIR_CCW = 1'b1;

   // A single channel still needs a one-bit index so port widths stay legal.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_delta_calc_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requester at or after the pointer, as one-hot and binary index.
module multi_delta_calc_rr_arbiter
   import multi_delta_calc_pkg::*;
#(
   parameter int NUM_CH = 4,
   localparam int IDX_W = idx_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NUM_CH-1:0] grant_o,
   output logic [IDX_W-1:0]  grant_idx_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand        = '0;
      for (int off = 0; off < NUM_CH; off++) begin
         cand = IDX_W'((int'(ptr_i) + off) % NUM_CH);
         if (!found && req_i[cand]) begin
            grant_o[cand] = 1'b1;
            grant_idx_o   = cand;
            found         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multi_delta_calc.sv
// Multi-channel shortest-path angular delta calculator with one shared, registered datapath.
// Channels are served round-robin, four cycles each: grant, subtract, resolve, report.
module multi_delta_calc
   import multi_delta_calc_pkg::*;
#(
   parameter int                 NUM_CH   = 4,
   parameter int                 ANGLE_W  = 12,
   parameter logic [ANGLE_W-1:0] DEADBAND = '0
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic [NUM_CH-1:0]           enable_calc,
   input  logic [NUM_CH*ANGLE_W-1:0]   target_angle,
   input  logic [NUM_CH*ANGLE_W-1:0]   current_angle,
   output logic [NUM_CH*ANGLE_W-1:0]   delta_angle,
   output logic [NUM_CH-1:0]           dir_shortest,
   output logic [NUM_CH-1:0]           at_target,
   output logic [NUM_CH-1:0]           calc_updated,
   output logic                        busy
);

   localparam int                 IDX_W = idx_width(NUM_CH);
   localparam logic [ANGLE_W-1:0] HALF  = {1'b1, {(ANGLE_W-1){1'b0}}};

   state_e                      state_q,   state_d;
   logic [NUM_CH-1:0]           pending_q, pending_d;
   logic [IDX_W-1:0]            rr_ptr_q,  rr_ptr_d;
   logic [NUM_CH*ANGLE_W-1:0]   delta_q,   delta_d;
   logic [NUM_CH-1:0]           dir_q,     dir_d;
   logic [NUM_CH-1:0]           at_q,      at_d;
   logic [NUM_CH-1:0]           upd_q,     upd_d;

   logic [IDX_W-1:0]            ch_q,      ch_d;
   logic [ANGLE_W-1:0]          tgt_q,     tgt_d;
   logic [ANGLE_W-1:0]          cur_q,     cur_d;
   logic [ANGLE_W-1:0]          diff_q,    diff_d;
   logic [ANGLE_W-1:0]          delta_r_q, delta_r_d;
   logic                        dir_r_q,   dir_r_d;

   logic [NUM_CH-1:0]           req;
   logic [NUM_CH-1:0]           arb_grant;
   logic [IDX_W-1:0]            arb_idx;
   logic [NUM_CH-1:0]           grant_now;

   assign req = pending_q | enable_calc;

   multi_delta_calc_rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arbiter (
      .req_i       (req),
      .ptr_i       (rr_ptr_q),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx)
   );

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      delta_d   = delta_q;
      dir_d     = dir_q;
      at_d      = at_q;
      upd_d     = '0;
      ch_d      = ch_q;
      tgt_d     = tgt_q;
      cur_d     = cur_q;
      diff_d    = diff_q;
      delta_r_d = delta_r_q;
      dir_r_d   = dir_r_q;
      grant_now = '0;

      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               grant_now = arb_grant;
               ch_d      = arb_idx;
               tgt_d     = target_angle[int'(arb_idx)*ANGLE_W +: ANGLE_W];
               cur_d     = current_angle[int'(arb_idx)*ANGLE_W +: ANGLE_W];
               state_d   = ST_CALC;
            end
         end
         ST_CALC: begin
            diff_d  = tgt_q - cur_q;
            state_d = ST_RESOLVE;
         end
         ST_RESOLVE: begin
            // Zero and exactly-half differences both resolve to CCW.
            if ((diff_q != '0) && (diff_q < HALF)) begin
               delta_r_d = diff_q;
               dir_r_d   = DIR_CW;
            end else begin
               delta_r_d = '0 - diff_q;
               dir_r_d   = DIR_CCW;
            end
            state_d = ST_REPORT;
         end
         ST_REPORT: begin
            delta_d[int'(ch_q)*ANGLE_W +: ANGLE_W] = delta_r_q;
            dir_d[ch_q] = dir_r_q;
            at_d[ch_q]  = (delta_r_q <= DEADBAND);
            upd_d[ch_q] = 1'b1;
            rr_ptr_d    = (ch_q == IDX_W'(NUM_CH-1)) ? '0 : ch_q + 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new request in the grant cycle re-arms the channel rather than being lost.
   assign pending_d = (pending_q & ~grant_now) | enable_calc;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         pending_q <= '0;
         rr_ptr_q  <= '0;
         delta_q   <= '0;
         dir_q     <= '0;
         at_q      <= '0;
         upd_q     <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rr_ptr_q  <= rr_ptr_d;
         delta_q   <= delta_d;
         dir_q     <= dir_d;
         at_q      <= at_d;
         upd_q     <= upd_d;
      end
   end

   // NOTE: datapath registers carry no reset; each is written before the FSM consumes it.
   always_ff @(posedge clock) begin
      ch_q      <= ch_d;
      tgt_q     <= tgt_d;
      cur_q     <= cur_d;
      diff_q    <= diff_d;
      delta_r_q <= delta_r_d;
      dir_r_q   <= dir_r_d;
   end

   assign delta_angle  = delta_q;
   assign dir_shortest = dir_q;
   assign at_target    = at_q;
   assign calc_updated = upd_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multi_delta_calc.sv
// Self-checking bench for multi_delta_calc: scoreboard of expected reports checked on each calc_updated pulse,
// plus directed checks for reset, busy and a second instance with a non-zero deadband.
module tb_multi_delta_calc;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [3:0]  enable_calc, enable_b;
   logic [47:0] target_angle, current_angle, target_b, current_b;
   logic [47:0] delta_angle, delta_b;
   logic [3:0]  dir_shortest, at_target, calc_updated;
   logic [3:0]  dir_b, at_b, upd_b;
   logic        busy, busy_b;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int         ch;
      logic [11:0] delta;
      logic       dir;
      logic       at;
      int         cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [11:0] m_delta[4];
   logic [3:0]  m_dir, m_at;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   multi_delta_calc #(.NUM_CH(4), .ANGLE_W(12), .DEADBAND(12'd0)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable_calc   (enable_calc),
      .target_angle  (target_angle),
      .current_angle (current_angle),
      .delta_angle   (delta_angle),
      .dir_shortest  (dir_shortest),
      .at_target     (at_target),
      .calc_updated  (calc_updated),
      .busy          (busy)
   );

   multi_delta_calc #(.NUM_CH(4), .ANGLE_W(12), .DEADBAND(12'd8)) dut_db (
      .clock         (clock),
      .reset_n       (reset_n),
      .enable_calc   (enable_b),
      .target_angle  (target_b),
      .current_angle (current_b),
      .delta_angle   (delta_b),
      .dir_shortest  (dir_b),
      .at_target     (at_b),
      .calc_updated  (upd_b),
      .busy          (busy_b)
   );

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [47:0] model_delta();
      return {m_delta[3], m_delta[2], m_delta[1], m_delta[0]};
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 4; i++) m_delta[i] = '0;
      m_dir = '0;
      m_at  = '0;
   endtask

   task automatic push(input int ch, input int d, input bit dir, input bit at, input int cy);
      exp_t e;
      e.ch = ch; e.delta = 12'(d); e.dir = dir; e.at = at; e.cyc = cy;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_cyc(input int t);
      for (int k = 0; k < 1000; k++) begin
         @(negedge clock);
         if (cyc >= t) break;
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clock);
      check("sb_drain", sb.size(), 0);
   endtask

   // Every pulse pops one expected report; the whole output bus is compared so held channels are covered too.
   always @(negedge clock) begin
      if (mon_en && calc_updated !== 4'b0) begin
         if (sb.size() == 0) begin
            check("unexpected_pulse", calc_updated, 0);
         end else begin
            mon_e = sb.pop_front();
            m_delta[mon_e.ch] = mon_e.delta;
            m_dir[mon_e.ch]   = mon_e.dir;
            m_at[mon_e.ch]    = mon_e.at;
            check("pulse_ch",    calc_updated, 4'b1 << mon_e.ch);
            check("pulse_cycle", cyc, mon_e.cyc);
            check("delta_bus",   delta_angle, model_delta());
            check("dir_bus",     dir_shortest, m_dir);
            check("at_bus",      at_target, m_at);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      reset_n = 1'b0;
      enable_calc = '0; target_angle = '0; current_angle = '0;
      enable_b = '0; target_b = '0; current_b = '0;
      clear_model();

      // Reset state
      step(); step();
      @(negedge clock);
      check("rst_delta", delta_angle, 0);
      check("rst_dir",   dir_shortest, 0);
      check("rst_at",    at_target, 0);
      check("rst_upd",   calc_updated, 0);
      check("rst_busy",  busy, 0);
      check("rst_busy_db", busy_b, 0);
      step();
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // A one-cycle request issued while IDLE is granted and also re-latched in pending, so it is served twice.
      // ch0: 100 - 4000 wraps to 196, CW
      target_angle[11:0] = 12'd100; current_angle[11:0] = 12'd4000;
      enable_calc = 4'b0001; c = cyc;
      push(0, 196, 1'b0, 1'b0, c + 4);
      push(0, 196, 1'b0, 1'b0, c + 8);
      step(); enable_calc = '0;
      wait_drain(20);
      check("busy_after_ch0", busy, 0);

      // ch1: 4000 - 100 = 3900 -> 196 CCW; ch0 must hold
      step();
      target_angle[23:12] = 12'd4000; current_angle[23:12] = 12'd100;
      enable_calc = 4'b0010; c = cyc;
      push(1, 196, 1'b1, 1'b0, c + 4);
      push(1, 196, 1'b1, 1'b0, c + 8);
      step(); enable_calc = '0;
      wait_drain(20);

      // ch3 half-turn tie: diff 2048 -> delta 2048 CCW
      step();
      target_angle[47:36] = 12'd2048; current_angle[47:36] = 12'd0;
      enable_calc = 4'b1000; c = cyc;
      push(3, 2048, 1'b1, 1'b0, c + 4);
      push(3, 2048, 1'b1, 1'b0, c + 8);
      step(); enable_calc = '0;
      wait_drain(20);

      // ch3 zero tie, then all four pulsed while busy with ch3's second service
      step();
      target_angle[47:36] = 12'd500; current_angle[47:36] = 12'd500;
      target_angle[35:24] = 12'd10;  current_angle[35:24] = 12'd5;
      enable_calc = 4'b1000; c = cyc;
      push(3, 0, 1'b1, 1'b1, c + 4);
      push(3, 0, 1'b1, 1'b1, c + 8);
      push(0, 196, 1'b0, 1'b0, c + 12);
      push(1, 196, 1'b1, 1'b0, c + 16);
      push(2, 5, 1'b0, 1'b0, c + 20);
      push(3, 0, 1'b1, 1'b1, c + 24);
      step(); enable_calc = '0;
      repeat (4) step();
      enable_calc = 4'b1111;
      step(); enable_calc = '0;
      wait_cyc(c + 23);
      check("busy_during_ch3", busy, 1);
      wait_cyc(c + 24);
      check("busy_drops_after_ch3", busy, 0);
      wait_drain(10);

      // Reset during RESOLVE of ch2
      step();
      enable_calc = 4'b0100; c = cyc;
      step(); enable_calc = '0;
      step(); reset_n = 1'b0;
      step();
      @(negedge clock);
      check("midrst_delta", delta_angle, 0);
      check("midrst_dir",   dir_shortest, 0);
      check("midrst_at",    at_target, 0);
      check("midrst_upd",   calc_updated, 0);
      check("midrst_busy",  busy, 0);
      clear_model();
      step(); reset_n = 1'b1;
      repeat (10) step();
      check("midrst_idle", busy, 0);

      // Grant restarts at ch0: ch0, ch2, then ch0 again from its re-latched request
      enable_calc = 4'b0101; c = cyc;
      push(0, 196, 1'b0, 1'b0, c + 4);
      push(2, 5, 1'b0, 1'b0, c + 8);
      push(0, 196, 1'b0, 1'b0, c + 12);
      step(); enable_calc = '0;
      wait_drain(30);

      // Deadband 8: delta 8 -> at_target, delta 9 -> not
      step();
      target_b[11:0] = 12'd108; current_b[11:0] = 12'd100;
      enable_b = 4'b0001; c = cyc;
      step(); enable_b = '0;
      wait_cyc(c + 4);
      check("db8_upd",   upd_b, 4'b0001);
      check("db8_delta", delta_b, {36'd0, 12'd8});
      check("db8_dir",   dir_b, 4'b0000);
      check("db8_at",    at_b, 4'b0001);
      wait_cyc(c + 9);
      check("db8_idle",  busy_b, 0);
      step();
      target_b[23:12] = 12'd91; current_b[23:12] = 12'd100;
      enable_b = 4'b0010; c = cyc;
      step(); enable_b = '0;
      wait_cyc(c + 4);
      check("db9_upd",   upd_b, 4'b0010);
      check("db9_delta", delta_b, {24'd0, 12'd9, 12'd8});
      check("db9_dir",   dir_b, 4'b0010);
      check("db9_at",    at_b, 4'b0001);
      wait_cyc(c + 10);

      check("sb_final", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
